// File: rtl/srl_fifo32x9_rd.sv
// Read end of a 32x9 SRL-based FIFO: shift-register storage addressed by occupancy,
// followed by a registered valid/ready output stage.
module srl_fifo32x9_rd #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             we,
    output logic             full,
    output logic [WIDTH-1:0] y,
    output logic             vld,
    input  logic             rdy,
    output logic [AW:0]      level,
    output logic             ovf
);

    logic [WIDTH-1:0] r_srl [DEPTH];
    logic [AW:0]      r_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_vld;
    logic             r_ovf;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_q;

    assign w_full = (r_cnt == (AW+1)'(DEPTH));
    assign w_push = we & ~w_full;
    assign w_pop  = (r_cnt != '0) & (~r_vld | rdy);
    // Oldest word always sits at cnt-1; meaningless (and unused) when empty.
    assign w_addr = r_cnt[AW-1:0] - AW'(1);
    assign w_q    = r_srl[w_addr];

    // Storage carries no reset so it can map onto SRL primitives.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_srl[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_y   <= '0;
            r_vld <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (w_pop) begin
                r_y   <= w_q;
                r_vld <= 1'b1;
            end else if (r_vld && rdy) begin
                r_vld <= 1'b0;
            end

            if (we && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign full  = w_full;
    assign y     = r_y;
    assign vld   = r_vld;
    assign ovf   = r_ovf;
    assign level = r_cnt + (AW+1)'(r_vld);

endmodule

// File: tb/tb_srl_fifo32x9_rd.sv
// Directed vector table plus hand-written fill/drain, random and reset sequences
// for srl_fifo32x9_rd.
module tb_srl_fifo32x9_rd;

    logic       clk;
    logic       rst_n;
    logic [8:0] d;
    logic       we;
    logic       full;
    logic [8:0] y;
    logic       vld;
    logic       rdy;
    logic [5:0] level;
    logic       ovf;

    int n_pass;
    int n_tot;

    srl_fifo32x9_rd #(
        .WIDTH (9),
        .DEPTH (32),
        .AW    (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .we    (we),
        .full  (full),
        .y     (y),
        .vld   (vld),
        .rdy   (rdy),
        .level (level),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [8:0] d;
        logic       rdy;
        logic       exp_vld;
        logic [8:0] exp_y;
        logic [5:0] exp_level;
        logic       exp_full;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we    = 1'b0;
        rdy   = 1'b0;
        d     = '0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int   q_model [$];
        int   exp_w;
        logic hs;
        logic pu;
        logic [8:0] y_pre;
        logic [8:0] d_pre;

        n_pass = 0;
        n_tot  = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        rdy    = 1'b0;
        d      = '0;

        // Vectors: inputs applied before the edge, outputs expected after it.
        vecs[0] = '{1'b1, 9'h1A5, 1'b1, 1'b0, 9'h000, 6'd1, 1'b0};
        vecs[1] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1A5, 6'd1, 1'b0};
        vecs[2] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h1A5, 6'd0, 1'b0};
        // Streaming: one word parked in the SRL plus one in y keeps level at 2.
        vecs[3] = '{1'b1, 9'h010, 1'b1, 1'b0, 9'h1A5, 6'd1, 1'b0};
        vecs[4] = '{1'b1, 9'h011, 1'b1, 1'b1, 9'h010, 6'd2, 1'b0};
        vecs[5] = '{1'b1, 9'h012, 1'b1, 1'b1, 9'h011, 6'd2, 1'b0};
        vecs[6] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h012, 6'd1, 1'b0};
        vecs[7] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h012, 6'd0, 1'b0};

        #2;
        chk("rst_vld", int'(vld), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(ovf), 0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            we  = vecs[i].we;
            d   = vecs[i].d;
            rdy = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_vld", i), int'(vld), int'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].exp_y));
            chk($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].exp_level));
            chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
        end

        // Fill with the consumer stalled: 32 in the SRL plus 1 in y.
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            we = 1'b1;
            d  = 9'(i);
            tick();
        end
        chk("fill_full", int'(full), 1);
        chk("fill_level", int'(level), 33);
        chk("fill_ovf", int'(ovf), 0);
        chk("fill_y", int'(y), 0);
        d = 9'h021;
        tick();
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_level", int'(level), 33);
        we = 1'b0;

        // Drain in order, one word per clock.
        rdy = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            chk($sformatf("drain%0d_vld", i), int'(vld), 1);
            chk($sformatf("drain%0d_y", i), int'(y), i);
            tick();
            if (i == 0) chk("drain_full_drop", int'(full), 0);
        end
        chk("drain_vld", int'(vld), 0);
        chk("drain_level", int'(level), 0);
        chk("drain_ovf_sticky", int'(ovf), 1);

        // Random traffic against a word-order queue; level is total words held.
        do_reset();
        q_model.delete();
        for (int c = 0; c < 10000; c++) begin
            chk("rnd_level", int'(level), q_model.size());
            if (ovf) chk("rnd_ovf", int'(ovf), 0);
            we   = ($urandom_range(1) == 1) && !full;
            rdy  = ($urandom_range(1) == 1);
            d    = 9'($urandom);
            hs    = vld & rdy;
            pu    = we;
            y_pre = y;
            d_pre = d;
            @(posedge clk);
            if (hs) begin
                if (q_model.size() == 0) begin
                    chk("rnd_underflow", 1, 0);
                end else begin
                    exp_w = q_model.pop_front();
                    chk("rnd_data", int'(y_pre), exp_w);
                end
            end
            if (pu) q_model.push_back(int'(d_pre));
            #1;
        end
        chk("rnd_ovf_end", int'(ovf), 0);

        // Asynchronous reset mid-stream.
        we  = 1'b0;
        rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            we = 1'b1;
            d  = 9'(9'h0A0 + i);
            tick();
        end
        we = 1'b0;
        chk("pre_rst_level", int'(level), 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", int'(vld), 0);
        chk("arst_full", int'(full), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_ovf", int'(ovf), 0);
        chk("arst_y", int'(y), 0);
        #1;
        rst_n = 1'b1;
        tick();
        we  = 1'b1;
        d   = 9'h155;
        rdy = 1'b1;
        tick();
        we = 1'b0;
        chk("post_rst_vld0", int'(vld), 0);
        tick();
        chk("post_rst_vld1", int'(vld), 1);
        chk("post_rst_y", int'(y), 'h155);
        chk("post_rst_level", int'(level), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
